// File: rtl/div5_pkg.sv
// Shared constants and FSM state type for the divide-by-5 round-trip path.
// The quotient reconstructor and its chunk multiplier import this package.
package div5_pkg;

  localparam int DIVISOR = 5;
  localparam int CHUNK   = 4;
  localparam int WIDTH   = 64;
  localparam int N_STEPS = WIDTH / CHUNK;
  localparam int CARRY_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mul5_chunk.sv
// One digit of the serial multiply: {carry_out, digit} = digit_in*DV + carry_in.
// Purely combinational; the top registers the carry between steps.
module mul5_chunk
  import div5_pkg::*;
#(
  parameter int CW = CHUNK,
  parameter int DV = DIVISOR,
  parameter int KW = CARRY_W
) (
  input  logic [CW-1:0] digit_in,
  input  logic [KW-1:0] carry_in,
  output logic [CW-1:0] digit,
  output logic [KW-1:0] carry_out
);

  localparam int SW = CW + KW;

  logic [SW-1:0] s;

  assign s         = SW'(digit_in) * SW'(DV) + SW'(carry_in);
  assign digit     = s[CW-1:0];
  assign carry_out = s[SW-1:CW];

endmodule

// File: rtl/mul5_recon_serial.sv
// Digit-serial rebuild of D = Q*DIVISOR + R, CHUNK quotient bits per cycle,
// LSB first, one operation in flight behind valid/ready on both sides.
module mul5_recon_serial
  import div5_pkg::*;
#(
  parameter int WIDTH   = div5_pkg::WIDTH,
  parameter int CHUNK   = div5_pkg::CHUNK,
  parameter int DIVISOR = div5_pkg::DIVISOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             ovf,
  output logic             r_err
);

  localparam int NSTEP = WIDTH / CHUNK;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);
  localparam logic [2:0]       RMAX = 3'(DIVISOR);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   sq;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   res_nxt;
  logic [CARRY_W-1:0] carry;
  logic [CARRY_W-1:0] c_nxt;
  logic [CHUNK-1:0]   dig;
  logic [CNT_W-1:0]   cnt;

  logic acc;
  logic step;
  logic last;
  logic ret;

  mul5_chunk #(
    .CW(CHUNK),
    .DV(DIVISOR),
    .KW(CARRY_W)
  ) u_chunk (
    .digit_in (sq[CHUNK-1:0]),
    .carry_in (carry),
    .digit    (dig),
    .carry_out(c_nxt)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign acc  = in_valid & in_ready;
  assign step = (state == RUN);
  assign last = step & (cnt == LAST);
  assign ret  = out_valid & out_ready;

  // New digits enter at the MSB end so the LSB-first stream lands in place
  assign res_nxt = {dig, res[WIDTH-1:CHUNK]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      acc:     state_nxt = RUN;
      last:    state_nxt = DONE;
      ret:     state_nxt = IDLE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq    <= '0;
      res   <= '0;
      carry <= '0;
      cnt   <= '0;
      d     <= '0;
      ovf   <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (acc) begin
        sq    <= q;
        res   <= '0;
        carry <= r;
        cnt   <= '0;
        r_err <= (r >= RMAX);
      end
      if (step) begin
        sq    <= sq >> CHUNK;
        res   <= res_nxt;
        carry <= c_nxt;
        cnt   <= cnt + 1'b1;
        if (last) begin
          d   <= res_nxt;
          ovf <= |c_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul5_recon_serial.sv
// Directed and randomised checks of the serial Q*5+R reconstructor.
// Expected values are hand-computed constants or a wide arithmetic model.
module tb_mul5_recon_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] q = '0;
  logic [2:0]  r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] d;
  logic        ovf;
  logic        r_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul5_recon_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .r        (r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .ovf      (ovf),
    .r_err    (r_err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [63:0] qq, input logic [2:0] rr,
                        input int ig, input int og,
                        output logic [63:0] dd, output logic oo,
                        output logic ee, output int lat);
    int n;
    repeat (ig) tick();
    q = qq;
    r = rr;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    q = {$urandom, $urandom};
    r = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    repeat (og) tick();
    dd = d;
    oo = ovf;
    ee = r_err;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("retire_ov", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] dd;
    logic        oo;
    logic        ee;
    int          lat;
    int          n;
    logic [63:0] qq;
    logic [2:0]  rr;
    logic [66:0] ex;

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", d, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_r_err", 64'(r_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(64'd0, 3'd0, 0, 0, dd, oo, ee, lat);
    chk("zero_d", dd, 64'd0);
    chk("zero_ovf", 64'(oo), 64'd0);
    chk("zero_r_err", 64'(ee), 64'd0);
    chk("zero_latency", 64'(lat), 64'd16);

    run_op(64'h3333_3333_3333_3333, 3'd0, 1, 0, dd, oo, ee, lat);
    chk("all_ones_d", dd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("all_ones_ovf", 64'(oo), 64'd0);
    chk("all_ones_latency", 64'(lat), 64'd16);

    run_op(64'h3333_3333_3333_3333, 3'd1, 0, 2, dd, oo, ee, lat);
    chk("wrap_d", dd, 64'd0);
    chk("wrap_ovf", 64'(oo), 64'd1);

    run_op(64'd1, 3'd4, 0, 0, dd, oo, ee, lat);
    chk("q1r4_d", dd, 64'd9);
    chk("q1r4_ovf", 64'(oo), 64'd0);
    chk("q1r4_r_err", 64'(ee), 64'd0);

    run_op(64'd2, 3'd6, 0, 0, dd, oo, ee, lat);
    chk("q2r6_d", dd, 64'd16);
    chk("q2r6_r_err", 64'(ee), 64'd1);

    q = 64'd1;
    r = 3'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      q = 64'h0000_0000_0000_DEAD;
      r = 3'd2;
      chk("bp_d", d, 64'd9);
      chk("bp_ovf", 64'(ovf), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_d_after", d, 64'd9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_retire_ov", 64'(out_valid), 64'd0);
    chk("bp_retire_ir", 64'(in_ready), 64'd1);

    q = 64'hFFFF_FFFF_FFFF_FFFF;
    r = 3'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_ir", 64'(in_ready), 64'd1);
    chk("mid_rst_d", d, 64'd0);
    chk("mid_rst_r_err", 64'(r_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ov", 64'(out_valid), 64'd0);
    chk("rel_ir", 64'(in_ready), 64'd1);
    repeat (20) tick();
    chk("rel_no_ghost", 64'(out_valid), 64'd0);
    run_op(64'd7, 3'd3, 0, 0, dd, oo, ee, lat);
    chk("post_rst_d", dd, 64'd38);
    chk("post_rst_ovf", 64'(oo), 64'd0);

    for (int k = 0; k < 2000; k++) begin
      qq = {$urandom, $urandom};
      if (k % 2 == 0) qq = qq / 5;
      if (k % 4 == 1) rr = 3'($urandom_range(0, 7));
      else rr = 3'($urandom_range(0, 4));
      run_op(qq, rr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             dd, oo, ee, lat);
      ex = 67'(qq) * 67'd5 + 67'(rr);
      chk("rnd_d", dd, ex[63:0]);
      chk("rnd_ovf", 64'(oo), 64'(ex[66:64] != 3'd0));
      chk("rnd_r_err", 64'(ee), 64'(rr >= 3'd5));
      chk("rnd_latency", 64'(lat), 64'd16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
